aes_encrypt: RTL and testbench
==============================

AES_ENCRYPT -- requirements
Module: aes_encrypt

Interface
REQ-001 Parameter Nk, default 4, key length in 32-bit words (AES-128 only).
REQ-002 Parameter Nr, default 10, number of cipher rounds.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 data_in  input  128  plaintext block; byte 0 at [127:120], column-major per FIPS-197.
REQ-007 all_keys  input  1408  expanded key schedule of 11 round keys; round key i at bits [1407-128*i -: 128], so round key 0 (cipher key) is [1407:1280].
REQ-008 data_out  output  128  current state register, same byte order as data_in.
REQ-009 done  output  1  high when data_out holds the final ciphertext.

Function
REQ-010 The block SHALL be iterative: one 128-bit state register, a round counter 0..Nr, one round per clock.
REQ-011 Round-counter value 0, on the first clock edge with reset low: state <= data_in XOR round key 0, counter <= 1.
REQ-012 Counter 1..Nr-1: state <= MixColumns(ShiftRows(SubBytes(state))) XOR round key[counter], counter increments.
REQ-013 Counter Nr: state <= ShiftRows(SubBytes(state)) XOR round key Nr (no MixColumns), done <= 1, counter stays at Nr.
REQ-014 Once done=1, state, counter and done SHALL hold until reset; further clocks cause no change.
REQ-015 Latency: ciphertext valid on data_out, with done=1, after exactly Nr+1 = 11 rising edges following reset deassertion.
REQ-016 data_out SHALL equal the state register at all times; intermediate round states are visible in cycles 1..10.
REQ-017 data_in is sampled only at counter 0; all_keys is read combinationally each round; changes at other times affect only later rounds that use them.
REQ-018 SubBytes SHALL use the FIPS-197 S-box: 16 parallel combinational instances, implemented as a 256-entry table or GF(2^8) inverse plus affine transform.
REQ-019 ShiftRows: row r is rotated left by r bytes.
REQ-020 MixColumns SHALL use the fixed matrix {02,03,01,01} over GF(2^8), with xtime reduction polynomial 0x11B.
REQ-021 The block SHALL contain no internal key expansion and SHALL use no handshake other than reset and done.

Reset
REQ-022 While reset=1 at a clock edge: state <= 0, counter <= 0, done <= 0; data_out reads 128'h0.
REQ-023 Reset asserted mid-operation SHALL abort the block within one edge; encryption restarts from counter 0 on the first edge with reset low.
REQ-024 Reset takes priority over every round operation.

Verification
REQ-025 Key 000102030405060708090a0b0c0d0e0f (expanded), data_in 00112233445566778899aabbccddeeff, reset released -> edge 1: data_out 00102030405060708090a0b0c0d0e0f0; edge 2: 89d810e8855ace682d1843d8cb128fe4; edge 11: 69c4e0d86a7b0430d8cdb78070b4c55a with done=1.
REQ-026 Key 2b7e151628aed2a6abf7158809cf4f3c, data_in 3243f6a8885a308d313198a2e0370734 -> after 11 edges data_out 3925841d02dc09fbdc118597196a0b32, done=1.
REQ-027 All-zero key schedule of the zero key, data_in 0 -> data_out 66e94bd4ef8a2c3b884cfa59ca342b2e after 11 edges.
REQ-028 Clock 5 further edges after done -> data_out and done unchanged.
REQ-029 Assert reset at edge 5 of REQ-025, release -> data_out 0 during reset; the REQ-025 sequence then repeats exactly, ciphertext at edge 11 after release.
REQ-030 Change data_in after edge 1 -> final ciphertext still matches the originally sampled plaintext.

Source files
------------

// File: rtl/aes_encrypt.sv
// rtl/aes_encrypt.sv - iterative AES-128 encryption core, one round per clock
// Consumes a pre-expanded key schedule; no key expansion and no handshake beyond reset/done.

module aes_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits in the top byte of the packed table.
    logic [10:0] idx;
    assign idx = 11'd2047 - {a_i, 3'b000};
    assign y_o = SBOX[idx -: 8];
endmodule

module aes_encrypt #(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [127:0]                data_in,
    input  logic [32*Nk*(Nr+1)-1:0]     all_keys,
    output logic [127:0]                data_out,
    output logic                        done
);
    localparam int KW = 32 * Nk * (Nr + 1);
    localparam int CW = $clog2(Nr + 1);

    logic [127:0]  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;

    logic [7:0]    st_b [16];
    logic [7:0]    sb_b [16];
    logic [7:0]    sr_b [16];
    logic [7:0]    mc_b [16];
    logic [127:0]  sr_w, mc_w, rk;
    logic [127:0]  rk_a [Nr+1];

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    for (genvar i = 0; i <= Nr; i++) begin : g_rk
        assign rk_a[i] = all_keys[KW-1-128*i -: 128];
    end
    assign rk = rk_a[cnt_q];

    // Byte k is row k%4, column k/4 of the column-major state.
    for (genvar k = 0; k < 16; k++) begin : g_bytes
        assign st_b[k] = state_q[127-8*k -: 8];
        aes_sbox u_sbox (.a_i(st_b[k]), .y_o(sb_b[k]));
        assign sr_w[127-8*k -: 8] = sr_b[k];
        assign mc_w[127-8*k -: 8] = mc_b[k];
    end

    for (genvar r = 0; r < 4; r++) begin : g_sr_row
        for (genvar c = 0; c < 4; c++) begin : g_sr_col
            assign sr_b[4*c+r] = sb_b[4*((c+r)%4)+r];
        end
    end

    for (genvar c = 0; c < 4; c++) begin : g_mc
        logic [7:0] a0, a1, a2, a3;
        assign a0 = sr_b[4*c+0];
        assign a1 = sr_b[4*c+1];
        assign a2 = sr_b[4*c+2];
        assign a3 = sr_b[4*c+3];
        assign mc_b[4*c+0] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        assign mc_b[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        assign mc_b[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        assign mc_b[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        if (cnt_q == '0) begin
            state_d = data_in ^ rk;
            cnt_d   = CW'(1);
        end else if (cnt_q == CW'(Nr)) begin
            state_d = sr_w ^ rk;
            done_d  = 1'b1;
        end else begin
            state_d = mc_w ^ rk;
            cnt_d   = cnt_q + 1'b1;
        end
    end

    // Once the ciphertext is out everything freezes until the next reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else if (!done_q) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign data_out = state_q;
    assign done     = done_q;
endmodule

// File: tb/tb_aes_encrypt.sv
// tb/tb_aes_encrypt.sv - scoreboard bench for aes_encrypt with FIPS-197 vectors
module tb_aes_encrypt;
    logic          clk;
    logic          reset;
    logic [127:0]  data_in;
    logic [1407:0] all_keys;
    logic [127:0]  data_out;
    logic          done;

    aes_encrypt dut (
        .clk(clk), .reset(reset), .data_in(data_in),
        .all_keys(all_keys), .data_out(data_out), .done(done)
    );

    localparam logic [1407:0] KS_C1 = {
        128'h000102030405060708090a0b0c0d0e0f, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
        128'hb692cf0b643dbdf1be9bc5006830b3fe, 128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
        128'h47f7f7bc95353e03f96c32bcfd058dfd, 128'h3caaa3e8a99f9deb50f3af57adf622aa,
        128'h5e390f7df7a69296a7553dc10aa31f6b, 128'h14f9701ae35fe28c440adf4d4ea9c026,
        128'h47438735a41c65b9e016baf4aebf7ad2, 128'h549932d1f08557681093ed9cbe2c974e,
        128'h13111d7fe3944a17f307a78b4d2b30c5};
    localparam logic [1407:0] KS_A1 = {
        128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    localparam logic [1407:0] KS_Z = {
        128'h00000000000000000000000000000000, 128'h62636363626363636263636362636363,
        128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa, 128'h90973450696ccffaf2f457330b0fac99,
        128'hee06da7b876a1581759e42b27e91ee2b, 128'h7f2e2b88f8443e098dda7cbbf34b9290,
        128'hec614b851425758c99ff09376ab49ba7, 128'h217517873550620bacaf6b3cc61bf09b,
        128'h0ef903333ba9613897060a04511dfa9f, 128'hb1d4d8e28a7db9da1d7bb3de4c664941,
        128'hb4ef5bcb3e92e21123e951cf6f8f188e};

    localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] E1_C1 = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] E2_C1 = 128'h89d810e8855ace682d1843d8cb128fe4;
    localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_A1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_A1 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    typedef struct {
        int           due;
        logic [127:0] d;
        logic         dn;
        bit           chk_d;
        string        nm;
    } exp_t;

    exp_t         cq[$];
    logic [127:0] fq[$];
    int           cyc = 0;
    int           n_chk = 0;
    int           n_fail = 0;
    bit           fin = 0;
    logic         done_prev = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int due, input logic [127:0] d, input logic dn,
                        input bit chk_d, input string nm);
        exp_t e;
        e.due = due; e.d = d; e.dn = dn; e.chk_d = chk_d; e.nm = nm;
        cq.push_back(e);
    endtask

    // Monitor: cycle-tagged expectations plus ciphertext popped on each done rise.
    always @(negedge clk) begin
        exp_t         e;
        logic [127:0] c;
        while (cq.size() > 0 && cq[0].due <= cyc) begin
            e = cq.pop_front();
            n_chk++;
            if (e.due < cyc) begin
                n_fail++;
                $display("FAIL %s: check for edge %0d missed at edge %0d", e.nm, e.due, cyc);
            end else if ((e.chk_d && data_out !== e.d) || done !== e.dn) begin
                n_fail++;
                $display("FAIL %s: got data_out=%h done=%b, expected data_out=%h done=%b",
                         e.nm, data_out, done, e.chk_d ? e.d : data_out, e.dn);
            end
        end
        if (done === 1'b1 && done_prev !== 1'b1) begin
            n_chk++;
            if (fq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: done rose at edge %0d with nothing expected", cyc);
            end else begin
                c = fq.pop_front();
                if (data_out !== c) begin
                    n_fail++;
                    $display("FAIL ciphertext: got %h, expected %h", data_out, c);
                end
            end
        end
        done_prev = done;
        if (fin) begin
            n_chk++;
            if (cq.size() != 0 || fq.size() != 0) begin
                n_fail++;
                $display("FAIL leftover: %0d cycle checks and %0d ciphertexts never seen",
                         cq.size(), fq.size());
            end
            $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
            $finish;
        end
    end

    // Entered with reset asserted, just after a rising edge.
    task automatic run(input logic [1407:0] ks, input logic [127:0] pt,
                       input bit has_e2, input logic [127:0] e2,
                       input logic [127:0] ct, input bit scramble);
        int base;
        all_keys = ks;
        data_in  = pt;
        push(cyc + 1, '0, 1'b0, 1'b1, "reset_state");
        @(posedge clk); #1;
        reset = 1'b0;
        base  = cyc;
        push(base + 1, pt ^ ks[1407:1280], 1'b0, 1'b1, "edge1_addkey");
        if (has_e2) push(base + 2, e2, 1'b0, 1'b1, "edge2_round1");
        push(base + 10, '0, 1'b0, 1'b0, "no_early_done");
        push(base + 11, ct, 1'b1, 1'b1, "edge11_final");
        push(base + 16, ct, 1'b1, 1'b1, "hold_after_done");
        fq.push_back(ct);
        @(posedge clk); #1;
        if (scramble) data_in = ~pt;
        while (cyc < base + 17) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
    endtask

    initial begin
        int base;
        reset    = 1'b1;
        data_in  = PT_C1;
        all_keys = KS_C1;
        @(posedge clk); #1;

        run(KS_C1, PT_C1, 1'b1, E2_C1, CT_C1, 1'b0);

        // Abort at edge 5, then the same vector again from scratch.
        push(cyc + 1, '0, 1'b0, 1'b1, "reset_before_abort");
        @(posedge clk); #1;
        reset = 1'b0;
        base  = cyc;
        push(base + 1, E1_C1, 1'b0, 1'b1, "abort_edge1");
        push(base + 2, E2_C1, 1'b0, 1'b1, "abort_edge2");
        repeat (3) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        push(base + 5, '0, 1'b0, 1'b1, "abort_clears");
        @(posedge clk); #1;
        run(KS_C1, PT_C1, 1'b1, E2_C1, CT_C1, 1'b0);

        run(KS_A1, PT_A1, 1'b0, '0, CT_A1, 1'b1);
        run(KS_Z, '0, 1'b0, '0, CT_Z, 1'b0);

        @(posedge clk); #1;
        fin = 1'b1;
        repeat (3) @(posedge clk);
        $display("FAIL monitor: summary not reached");
        $fatal(1);
    end
endmodule
